// File: rtl/spu32_cpu_alu_pkg.sv
// Shared ALU definitions: the opcode encodings used by the ALU and the decoder,
// plus the shift-direction type used by the serial shifter.
package spu32_cpu_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_e;

  localparam int unsigned XLEN = 32;

  function automatic logic is_shift_op(input alu_op_e op);
    case (op)
      ALU_SLL, ALU_SRL, ALU_SRA: is_shift_op = 1'b1;
      default:                   is_shift_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spu32_cpu_alu_shifter.sv
// Result register of the ALU plus the one-bit-per-cycle shift engine
// (down-counter and busy flag) that iterates on it.
module spu32_cpu_alu_shifter
  import spu32_cpu_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic [XLEN-1:0]   load_data_i,
  input  logic              shift_start_i,
  input  logic [4:0]        shift_amt_i,
  input  shift_kind_e       shift_kind_i,
  output logic [XLEN-1:0]   data_o,
  output logic              busy_o
);

  logic [XLEN-1:0] data_q, data_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  shift_kind_e     kind_q, kind_d;

  // Next-state: an active shift has priority; a load only happens when idle.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    kind_d = kind_q;
    if (busy_q) begin
      case (kind_q)
        SH_SLL:  data_d = {data_q[XLEN-2:0], 1'b0};
        SH_SRL:  data_d = {1'b0, data_q[XLEN-1:1]};
        SH_SRA:  data_d = {data_q[XLEN-1], data_q[XLEN-1:1]};
        default: data_d = data_q;
      endcase
      cnt_d  = cnt_q - 5'd1;
      busy_d = (cnt_q != 5'd1);
    end else if (load_i) begin
      data_d = load_data_i;
      if (shift_start_i && (shift_amt_i != 5'd0)) begin
        cnt_d  = shift_amt_i;
        busy_d = 1'b1;
        kind_d = shift_kind_i;
      end else begin
        cnt_d  = 5'd0;
        busy_d = 1'b0;
      end
    end else begin
      data_d = data_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= {XLEN{1'b0}};
      cnt_q  <= 5'd0;
      busy_q <= 1'b0;
      kind_q <= SH_SLL;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      kind_q <= kind_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/spu32_cpu_alu.sv
// SPU32 ALU: single-cycle arithmetic/logic/compare ops, serial shifts delegated
// to spu32_cpu_alu_shifter, and registered comparison flags.
module spu32_cpu_alu
  import spu32_cpu_alu_pkg::*;
(
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic              I_en,
  input  logic [3:0]        I_op,
  input  logic [XLEN-1:0]   I_dataS1,
  input  logic [XLEN-1:0]   I_dataS2,
  output logic [XLEN-1:0]   O_data,
  output logic              O_busy,
  output logic              O_eq,
  output logic              O_lt,
  output logic              O_ltu
);

  alu_op_e         op_s;
  logic            accept_s;
  logic            busy_s;
  logic [XLEN-1:0] result_s;
  logic            eq_s, lt_s, ltu_s;
  logic            eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;
  shift_kind_e     kind_s;

  assign op_s     = alu_op_e'(I_op);
  assign accept_s = I_en & ~busy_s;

  // Combinational result, comparisons and shift direction for the presented op.
  always_comb begin
    eq_s   = (I_dataS1 == I_dataS2);
    lt_s   = ($signed(I_dataS1) < $signed(I_dataS2));
    ltu_s  = (I_dataS1 < I_dataS2);
    kind_s = SH_SLL;
    case (op_s)
      ALU_ADD:   result_s = I_dataS1 + I_dataS2;
      ALU_SUB:   result_s = I_dataS1 - I_dataS2;
      ALU_AND:   result_s = I_dataS1 & I_dataS2;
      ALU_OR:    result_s = I_dataS1 | I_dataS2;
      ALU_XOR:   result_s = I_dataS1 ^ I_dataS2;
      ALU_SLT:   result_s = {31'd0, lt_s};
      ALU_SLTU:  result_s = {31'd0, ltu_s};
      ALU_PASSB: result_s = I_dataS2;
      // Shifts start from S1; the shifter walks it one bit per cycle.
      ALU_SLL: begin result_s = I_dataS1; kind_s = SH_SLL; end
      ALU_SRL: begin result_s = I_dataS1; kind_s = SH_SRL; end
      ALU_SRA: begin result_s = I_dataS1; kind_s = SH_SRA; end
      default:   result_s = 32'd0;
    endcase
  end

  // Flags update only on an accepted operation, otherwise hold.
  always_comb begin
    if (accept_s) begin
      eq_d  = eq_s;
      lt_d  = lt_s;
      ltu_d = ltu_s;
    end else begin
      eq_d  = eq_q;
      lt_d  = lt_q;
      ltu_d = ltu_q;
    end
  end

  // Flag registers with synchronous active-low reset.
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      ltu_q <= 1'b0;
    end else begin
      eq_q  <= eq_d;
      lt_q  <= lt_d;
      ltu_q <= ltu_d;
    end
  end

  spu32_cpu_alu_shifter u_shifter (
    .clk           (I_clk),
    .reset_n       (I_reset_n),
    .load_i        (accept_s),
    .load_data_i   (result_s),
    .shift_start_i (is_shift_op(op_s)),
    .shift_amt_i   (I_dataS2[4:0]),
    .shift_kind_i  (kind_s),
    .data_o        (O_data),
    .busy_o        (busy_s)
  );

  assign O_busy = busy_s;
  assign O_eq   = eq_q;
  assign O_lt   = lt_q;
  assign O_ltu  = ltu_q;

endmodule
